vga_frame_reader: RTL and testbench

//  Consumes the VGA timing generator's counters, syncs and visible flags. Fetches pixels from a

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_delay_line.sv | 27 ++
 rtl/vga_frame_reader.sv | 119 +++++++++++
 tb/tb_vga_frame_reader.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: colour word layout and 800x600@60 timing constants shared by the VGA pixel path.
package vga_pkg;

    localparam int COLOR_W = 4;

    // Framebuffer word layout: {r,g,b}, red in the most significant bits.
    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

    localparam int H_VISIBLE = 800;
    localparam int H_FRONT   = 40;
    localparam int H_SYNC    = 128;
    localparam int H_BACK    = 88;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 600;
    localparam int V_FRONT   = 1;
    localparam int V_SYNC    = 4;
    localparam int V_BACK    = 23;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with asynchronous reset to a chosen idle value.
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] taps [DEPTH];

    // Shift one tap per clock; reset forces every tap to the idle value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
        end else begin
            taps[0] <= d;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign q = taps[DEPTH-1];

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: fetches scaled framebuffer pixels and drives latency-matched RGB and syncs.
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int   H_VISIBLE   = 800,
    parameter int   H_CNT_W     = 11,
    parameter int   V_CNT_W     = 10,
    parameter int   SCALE_SHIFT = 1,
    parameter int   ADDR_W      = 18,
    parameter int   FB_LATENCY  = 1,
    parameter logic SYNC_IDLE   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [H_CNT_W-1:0]   h_pxl_count,
    input  logic [V_CNT_W-1:0]   v_pxl_count,
    input  logic                 h_sync,
    input  logic                 v_sync,
    input  logic                 h_visible,
    input  logic                 v_visible,
    input  logic [ADDR_W-1:0]    fb_base,
    output logic [ADDR_W-1:0]    fb_addr,
    output logic                 fb_rd_en,
    input  logic [3*COLOR_W-1:0] fb_rd_data,
    output logic [COLOR_W-1:0]   vga_r,
    output logic [COLOR_W-1:0]   vga_g,
    output logic [COLOR_W-1:0]   vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic                 frame_start
);

    localparam int                LAT      = FB_LATENCY + 2;
    localparam int                SUB_W    = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] FB_WIDTH = ADDR_W'(H_VISIBLE >> SCALE_SHIFT);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] cur_base;
    logic [SUB_W-1:0]  px_sub;
    logic [SUB_W-1:0]  line_sub;
    logic              h_vis_q;
    logic              frame_in;
    logic              rd_en_in;
    logic              line_end;
    logic              pix_en;
    logic [1:0]        sync_q;
    rgb_t              pix;

    assign frame_in = (h_pxl_count == '0) && (v_pxl_count == '0);
    assign rd_en_in = h_visible && v_visible;
    assign line_end = h_vis_q && !h_visible && v_visible;
    // Pixel (0,0) must already read from the newly requested base, before it is latched.
    assign cur_base = frame_in ? fb_base : row_base;

    // Column and row bookkeeping: replicate each fb pixel horizontally and each fb row vertically.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= '0;
            col      <= '0;
            px_sub   <= '0;
            line_sub <= '0;
            h_vis_q  <= 1'b0;
        end else begin
            h_vis_q <= h_visible;
            if (!h_visible) begin
                col    <= '0;
                px_sub <= '0;
            end else begin
                px_sub <= (px_sub == SUB_LAST) ? '0 : px_sub + 1'b1;
                col    <= (px_sub == SUB_LAST) ? col + 1'b1 : col;
            end
            if (frame_in) begin
                row_base <= fb_base;
                line_sub <= '0;
            end else if (line_end) begin
                line_sub <= (line_sub == SUB_LAST) ? '0 : line_sub + 1'b1;
                row_base <= (line_sub == SUB_LAST) ? row_base + FB_WIDTH : row_base;
            end
        end
    end

    // Stage A: issue the framebuffer read; the address holds through blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_addr  <= '0;
            fb_rd_en <= 1'b0;
        end else begin
            fb_rd_en <= rd_en_in;
            if (rd_en_in) fb_addr <= cur_base + col;
        end
    end

    // Stage B: capture returned data, forcing black outside the active region.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pix <= '0;
        else          pix <= pix_en ? rgb_t'(fb_rd_data) : '0;
    end

    assign vga_r  = pix.r;
    assign vga_g  = pix.g;
    assign vga_b  = pix.b;
    assign vga_hs = sync_q[1];
    assign vga_vs = sync_q[0];

    vga_delay_line #(.WIDTH(1), .DEPTH(LAT - 1), .RESET_VAL(1'b0)) u_en_dly (
        .clk(clk), .reset_n(reset_n), .d(rd_en_in), .q(pix_en)
    );

    vga_delay_line #(.WIDTH(2), .DEPTH(LAT), .RESET_VAL({SYNC_IDLE, SYNC_IDLE})) u_sync_dly (
        .clk(clk), .reset_n(reset_n), .d({h_sync, v_sync}), .q(sync_q)
    );

    vga_delay_line #(.WIDTH(1), .DEPTH(LAT), .RESET_VAL(1'b0)) u_fs_dly (
        .clk(clk), .reset_n(reset_n), .d(frame_in), .q(frame_start)
    );

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: 800x600 timing with skipped lines, fb model returning addr[11:0].
module tb_vga_frame_reader;
    import vga_pkg::*;

    localparam int LAT    = 3;
    localparam int NLINES = 12;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] h_pxl_count;
    logic [9:0]  v_pxl_count;
    logic        h_sync, v_sync, h_visible, v_visible;
    logic [17:0] fb_base;
    logic [17:0] fb_addr;
    logic        fb_rd_en;
    logic [11:0] fb_rd_data = '0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;

    always #5 clk = ~clk;

    vga_frame_reader dut (
        .clk(clk), .reset_n(reset_n),
        .h_pxl_count(h_pxl_count), .v_pxl_count(v_pxl_count),
        .h_sync(h_sync), .v_sync(v_sync), .h_visible(h_visible), .v_visible(v_visible),
        .fb_base(fb_base), .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_rd_data(fb_rd_data),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
    );

    // Synchronous-read framebuffer, one cycle latency.
    always @(posedge clk) if (fb_rd_en) fb_rd_data <= fb_addr[11:0];

    typedef struct {
        int f; int v; int h;
        logic hs; logic vs; logic fs; logic vis;
        logic [17:0] addr; logic [11:0] rgb;
    } rec_t;

    typedef struct {
        int f; int v; int h;
        logic [17:0] exp; logic [17:0] got; bit seen;
    } vec_t;

    rec_t hist[4];
    vec_t tbl[12];
    int   lines[NLINES] = '{0, 1, 2, 3, 300, 301, 599, 600, 601, 604, 605, 627};
    int   n_cmp = 0, n_bad = 0;
    int   k, hc, li, fno, seen_lines;
    logic [17:0] base_m, last_addr;
    int   hs_in_e = 0, vs_in_e = 0, hs_out_e = 0, vs_out_e = 0;
    logic hs_in_p = 1'b0, vs_in_p = 1'b0, hs_out_p = 1'b0, vs_out_p = 1'b0;
    int   fs_in_k[$], fs_out_k[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (step %0d): got %h expected %h", name, k, got, exp);
        end
    endtask

    // Timing generator plus reference model: each visible pixel maps to
    // base + (visible lines already delivered / 2) * 400 + h / 2, base taken at (0,0).
    task automatic drive();
        int   v = lines[li];
        logic vis, fs, hs;
        if (fno == 1 && v == 300 && hc == 0) fb_base = 18'h10000;
        else if (fno >= 2 && !(hc == 0 && v == 0) && $urandom_range(0, 499) == 0) fb_base = 18'($urandom);
        vis = (hc < H_VISIBLE) && (v < V_VISIBLE);
        fs  = (hc == 0) && (v == 0);
        hs  = (hc >= H_VISIBLE + H_FRONT) && (hc < H_VISIBLE + H_FRONT + H_SYNC);
        if (fno == 3 && $urandom_range(0, 299) == 0) hs = ~hs;
        h_pxl_count = 11'(hc);
        v_pxl_count = 10'(v);
        h_sync      = hs;
        v_sync      = (v >= V_VISIBLE + V_FRONT) && (v < V_VISIBLE + V_FRONT + V_SYNC);
        h_visible   = hc < H_VISIBLE;
        v_visible   = v < V_VISIBLE;
        if (fs) begin
            base_m     = fb_base;
            seen_lines = 0;
            fs_in_k.push_back(k);
        end
        if (vis) last_addr = base_m + 18'((seen_lines / 2) * (H_VISIBLE / 2) + hc / 2);
        if (vis && hc == H_VISIBLE - 1) seen_lines++;
        hist[k & 3] = '{f: fno, v: v, h: hc, hs: h_sync, vs: v_sync, fs: fs, vis: vis,
                        addr: last_addr, rgb: vis ? last_addr[11:0] : 12'h000};
        if (h_sync && !hs_in_p) hs_in_e++;
        if (v_sync && !vs_in_p) vs_in_e++;
        hs_in_p = h_sync;
        vs_in_p = v_sync;
        hc++;
        if (hc == H_TOTAL) begin
            hc = 0;
            li++;
            if (li == NLINES) begin
                li = 0;
                fno++;
            end
        end
    endtask

    task automatic check();
        rec_t a = hist[(k - 1) & 3];
        rec_t b = hist[(k - 3) & 3];
        chk("fetch {rd_en,addr}", {13'b0, fb_rd_en, fb_addr}, {13'b0, a.vis, a.addr});
        chk("pixel {hs,vs,fs,rgb}", {17'b0, vga_hs, vga_vs, frame_start, vga_r, vga_g, vga_b},
            {17'b0, b.hs, b.vs, b.fs, b.rgb});
        foreach (tbl[i])
            if (a.vis && tbl[i].f == a.f && tbl[i].v == a.v && tbl[i].h == a.h) begin
                tbl[i].got  = fb_addr;
                tbl[i].seen = 1'b1;
            end
        if (frame_start) fs_out_k.push_back(k);
        if (vga_hs && !hs_out_p) hs_out_e++;
        if (vga_vs && !vs_out_p) vs_out_e++;
        hs_out_p = vga_hs;
        vs_out_p = vga_vs;
    endtask

    initial begin
        tbl = '{
            '{1, 0,   0,   18'd0,       '0, 1'b0}, '{1, 0,   1,   18'd0,    '0, 1'b0},
            '{1, 0,   2,   18'd1,       '0, 1'b0}, '{1, 0,   3,   18'd1,    '0, 1'b0},
            '{1, 0,   799, 18'd399,     '0, 1'b0}, '{1, 1,   0,   18'd0,    '0, 1'b0},
            '{1, 1,   799, 18'd399,     '0, 1'b0}, '{1, 2,   0,   18'd400,  '0, 1'b0},
            '{1, 3,   799, 18'd799,     '0, 1'b0}, '{1, 300, 0,   18'd800,  '0, 1'b0},
            '{1, 599, 799, 18'd1599,    '0, 1'b0}, '{2, 0,   0,   18'h10000, '0, 1'b0}
        };
        foreach (hist[i]) hist[i] = '{-1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd0, 12'h000};
        reset_n = 1'b0;
        fb_base = '0;
        hc = 1000; li = NLINES - 1; fno = 0; k = 0;
        base_m = '0; last_addr = '0; seen_lines = 0;
        h_pxl_count = 11'd1000; v_pxl_count = 10'd627;
        h_sync = 1'b0; v_sync = 1'b0; h_visible = 1'b0; v_visible = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset fb_addr", 32'(fb_addr), 32'd0);
        chk("reset fb_rd_en", 32'(fb_rd_en), 32'd0);
        chk("reset rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("reset syncs", 32'({vga_hs, vga_vs}), 32'd0);
        chk("reset frame_start", 32'(frame_start), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        while (!(fno == 4 && li == 1 && hc == 400)) begin
            drive();
            @(negedge clk);
            check();
            k++;
            @(posedge clk);
            #1;
        end
        foreach (tbl[i])
            chk($sformatf("addr f%0d v%0d h%0d", tbl[i].f, tbl[i].v, tbl[i].h),
                {13'b0, tbl[i].seen, tbl[i].got}, {13'b0, 1'b1, tbl[i].exp});
        chk("frame_start count", 32'(fs_out_k.size()), 32'd4);
        for (int i = 0; i < fs_out_k.size() && i < fs_in_k.size(); i++)
            chk("frame_start latency", 32'(fs_out_k[i]), 32'(fs_in_k[i] + LAT));
        for (int i = 1; i < fs_out_k.size(); i++)
            chk("frame_start period", 32'(fs_out_k[i] - fs_out_k[i-1]), 32'(NLINES * H_TOTAL));
        chk("hsync pulses", 32'(hs_out_e), 32'(hs_in_e));
        chk("vsync pulses", 32'(vs_out_e), 32'(vs_in_e));
        chk("rd_en before reset", 32'(fb_rd_en), 32'd1);
        #3 reset_n = 1'b0;
        #1;
        chk("async reset rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        chk("async reset syncs", 32'({vga_hs, vga_vs}), 32'd0);
        chk("async reset fb_rd_en", 32'(fb_rd_en), 32'd0);
        chk("async reset frame_start", 32'(frame_start), 32'd0);
        chk("async reset fb_addr", 32'(fb_addr), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
